// File: rtl/imm_decode_stage_if.sv
// IF/ID to ID/EX immediate bus for the immediate decode stage.
// Inputs come from fetch/hazard logic, outputs feed ID/EX.
interface imm_decode_stage_if;
    logic [31:0] instr;
    logic        instr_valid;
    logic        stall;
    logic        flush;
    logic [63:0] imm;
    logic [2:0]  imm_kind;
    logic        imm_valid;
    logic        illegal;
    logic [15:0] fetch_count;

    modport master (
        output instr, instr_valid, stall, flush,
        input  imm, imm_kind, imm_valid, illegal, fetch_count
    );

    modport slave (
        input  instr, instr_valid, stall, flush,
        output imm, imm_kind, imm_valid, illegal, fetch_count
    );
endinterface

// File: rtl/imm_decode_stage.sv
// Immediate extraction stage: classifies the IF/ID word and registers
// the extended immediate, its kind, an illegal flag and an accept count.
module imm_decode_stage #(
    parameter int BR_SHIFT = 2
) (
    input  logic clk,
    input  logic reset,
    imm_decode_stage_if.slave bus
);

    localparam logic [2:0] K_NONE = 3'd0;
    localparam logic [2:0] K_D9   = 3'd1;
    localparam logic [2:0] K_I12  = 3'd2;
    localparam logic [2:0] K_CB19 = 3'd3;
    localparam logic [2:0] K_B26  = 3'd4;

    logic [31:0] w_i;
    logic        w_is_d9;
    logic        w_is_i12;
    logic        w_is_cb19;
    logic        w_is_b26;
    logic [63:0] w_cb19_sx;
    logic [63:0] w_b26_sx;
    logic [2:0]  w_kind;
    logic [63:0] w_imm;

    logic [63:0] r_imm;
    logic [2:0]  r_kind;
    logic        r_valid;
    logic        r_illegal;
    logic [15:0] r_count;

    assign w_i = bus.instr;

    assign w_is_d9   = (w_i[31:21] == 11'b11111000010)
                     | (w_i[31:21] == 11'b11111000000);
    assign w_is_i12  = (w_i[31:22] == 10'b1001000100)
                     | (w_i[31:22] == 10'b1101000100);
    assign w_is_cb19 = (w_i[31:24] == 8'b10110100)
                     | (w_i[31:24] == 8'b01010100);
    assign w_is_b26  = (w_i[31:26] == 6'b000101);

    assign w_cb19_sx = {{45{w_i[23]}}, w_i[23:5]};
    assign w_b26_sx  = {{38{w_i[25]}}, w_i[25:0]};

    // Classify the word (D9 first) and build the extended immediate.
    always_comb begin
        w_kind = K_NONE;
        w_imm  = 64'd0;
        priority case (1'b1)
            w_is_d9: begin
                w_kind = K_D9;
                w_imm  = {{55{w_i[20]}}, w_i[20:12]};
            end
            w_is_i12: begin
                w_kind = K_I12;
                w_imm  = {52'd0, w_i[21:10]};
            end
            w_is_cb19: begin
                w_kind = K_CB19;
                w_imm  = w_cb19_sx << BR_SHIFT;
            end
            w_is_b26: begin
                w_kind = K_B26;
                w_imm  = w_b26_sx << BR_SHIFT;
            end
            default: begin
                w_kind = K_NONE;
                w_imm  = 64'd0;
            end
        endcase
    end

    // Stage register: reset beats flush, flush beats stall.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_imm     <= 64'd0;
            r_kind    <= K_NONE;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
            r_count   <= 16'd0;
        end else if (bus.flush) begin
            r_imm     <= 64'd0;
            r_kind    <= K_NONE;
            r_valid   <= 1'b0;
            r_illegal <= 1'b0;
        end else if (!bus.stall) begin
            r_imm     <= w_imm;
            r_kind    <= w_kind;
            r_valid   <= bus.instr_valid;
            r_illegal <= bus.instr_valid
                       & (w_kind == K_NONE)
                       & (w_i != 32'd0);
            if (bus.instr_valid) begin
                r_count <= r_count + 16'd1;
            end
        end
    end

    assign bus.imm         = r_imm;
    assign bus.imm_kind    = r_kind;
    assign bus.imm_valid   = r_valid;
    assign bus.illegal     = r_illegal;
    assign bus.fetch_count = r_count;

endmodule

// File: tb/tb_imm_decode_stage.sv
// Self-checking bench for imm_decode_stage: directed cases plus
// randomized traffic against an arithmetic reference model.
module tb_imm_decode_stage;

    localparam int SH = 2;

    logic clk = 1'b0;
    logic reset = 1'b0;
    int   errors = 0;
    int   checks = 0;

    imm_decode_stage_if bus ();

    imm_decode_stage #(.BR_SHIFT(SH)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    always #5 clk = ~clk;

    logic [63:0] e_imm;
    logic [2:0]  e_kind;
    logic        e_valid;
    logic        e_ill;
    logic [15:0] e_cnt;

    // Reference decode from the opcode table using plain arithmetic.
    function automatic void ref_dec(input logic [31:0] w,
                                    output logic [2:0] k,
                                    output logic [63:0] v);
        longint f;
        longint s;
        k = 3'd0;
        v = 64'd0;
        if ((w >> 21) == 32'h7C2 || (w >> 21) == 32'h7C0) begin
            f = longint'((w >> 12) % 512);
            s = (f >= 256) ? f - 512 : f;
            k = 3'd1;
            v = 64'(s);
        end else if ((w >> 22) == 32'h244 || (w >> 22) == 32'h344) begin
            f = longint'((w >> 10) % 4096);
            k = 3'd2;
            v = 64'(f);
        end else if ((w >> 24) == 32'hB4 || (w >> 24) == 32'h54) begin
            f = longint'((w >> 5) % (1 << 19));
            s = (f >= (1 << 18)) ? f - (1 << 19) : f;
            k = 3'd3;
            v = 64'(s * (longint'(1) << SH));
        end else if ((w >> 26) == 32'h5) begin
            f = longint'(w % (1 << 26));
            s = (f >= (1 << 25)) ? f - (1 << 26) : f;
            k = 3'd4;
            v = 64'(s * (longint'(1) << SH));
        end
    endfunction

    // Advance one clock edge and the model with it.
    task automatic step();
        logic [2:0]  k;
        logic [63:0] v;
        @(posedge clk);
        ref_dec(bus.instr, k, v);
        if (reset) begin
            e_imm = 0; e_kind = 0; e_valid = 0; e_ill = 0; e_cnt = 0;
        end else if (bus.flush) begin
            e_imm = 0; e_kind = 0; e_valid = 0; e_ill = 0;
        end else if (!bus.stall) begin
            e_imm   = v;
            e_kind  = k;
            e_valid = bus.instr_valid;
            e_ill   = bus.instr_valid && k == 0 && bus.instr != 0;
            if (bus.instr_valid) e_cnt = e_cnt + 1;
        end
        #1;
    endtask

    function automatic logic [31:0] rnd_instr();
        logic [31:0] r;
        r = $urandom;
        case ($urandom_range(0, 6))
            0: rnd_instr = {10'b1111100001, r[0], r[20:0]} & 32'hFFDFFFFF;
            1: rnd_instr = {r[0], 9'b101000100, r[21:0]};
            2: rnd_instr = {r[0] ? 8'b10110100 : 8'b01010100, r[23:0]};
            3: rnd_instr = {6'b000101, r[25:0]};
            4: rnd_instr = 32'd0;
            default: rnd_instr = r;
        endcase
    endfunction

    task automatic drive(input logic [31:0] w, input logic v,
                         input logic st, input logic fl);
        bus.instr = w;
        bus.instr_valid = v;
        bus.stall = st;
        bus.flush = fl;
    endtask

    task automatic test_reset();
        drive(32'hDEADBEEF, 1'b1, 1'b1, 1'b1);
        reset = 1'b1;
        step();
        step();
        reset = 1'b0;
        drive(32'd0, 1'b0, 1'b0, 1'b0);
        checks++;
        if ({bus.imm, bus.imm_kind, bus.imm_valid, bus.illegal,
             bus.fetch_count} !== 86'd0) begin
            errors++;
            $display("FAIL reset: imm=%h kind=%0d v=%b ill=%b cnt=%0d required all zero",
                     bus.imm, bus.imm_kind, bus.imm_valid, bus.illegal,
                     bus.fetch_count);
        end
    endtask

    task automatic test_directed();
        logic [31:0] w [4];
        logic [63:0] ci [4];
        logic [2:0]  ck [4];
        w[0] = {11'b11111000010, 9'h1F8, 2'b00, 5'd1, 5'd2};
        w[1] = {10'b1001000100, 12'hFFF, 5'd3, 5'd4};
        w[2] = {6'b000101, 26'h3FFFFFF};
        w[3] = {8'b01010100, 19'd2, 5'd0};
        ci[0] = 64'hFFFFFFFFFFFFFFF8; ck[0] = 3'd1;
        ci[1] = 64'h0000000000000FFF; ck[1] = 3'd2;
        ci[2] = 64'hFFFFFFFFFFFFFFFC; ck[2] = 3'd4;
        ci[3] = 64'h0000000000000008; ck[3] = 3'd3;
        for (int i = 0; i < 4; i++) begin
            drive(w[i], 1'b1, 1'b0, 1'b0);
            step();
            checks++;
            if (bus.imm !== ci[i] || bus.imm_kind !== ck[i] ||
                bus.imm_valid !== 1'b1 || bus.illegal !== 1'b0 ||
                bus.fetch_count !== 16'(i + 1)) begin
                errors++;
                $display("FAIL directed%0d: imm=%h kind=%0d v=%b ill=%b cnt=%0d required imm=%h kind=%0d v=1 ill=0 cnt=%0d",
                         i, bus.imm, bus.imm_kind, bus.imm_valid,
                         bus.illegal, bus.fetch_count, ci[i], ck[i], i + 1);
            end
        end
    endtask

    task automatic test_stall_flush();
        logic [63:0] h_imm;
        logic [2:0]  h_kind;
        logic [15:0] h_cnt;
        h_imm = e_imm; h_kind = e_kind; h_cnt = e_cnt;
        for (int i = 0; i < 3; i++) begin
            drive(rnd_instr(), 1'b1, 1'b1, 1'b0);
            step();
            checks++;
            if (bus.imm !== h_imm || bus.imm_kind !== h_kind ||
                bus.imm_valid !== 1'b1 || bus.fetch_count !== h_cnt) begin
                errors++;
                $display("FAIL stall%0d: imm=%h kind=%0d v=%b cnt=%0d required imm=%h kind=%0d v=1 cnt=%0d",
                         i, bus.imm, bus.imm_kind, bus.imm_valid,
                         bus.fetch_count, h_imm, h_kind, h_cnt);
            end
        end
        drive({6'b000101, 26'h1}, 1'b1, 1'b1, 1'b1);
        step();
        checks++;
        if (bus.imm !== 64'd0 || bus.imm_valid !== 1'b0 ||
            bus.imm_kind !== 3'd0 || bus.illegal !== 1'b0 ||
            bus.fetch_count !== h_cnt) begin
            errors++;
            $display("FAIL flush_stall: imm=%h kind=%0d v=%b ill=%b cnt=%0d required imm=0 kind=0 v=0 ill=0 cnt=%0d",
                     bus.imm, bus.imm_kind, bus.imm_valid, bus.illegal,
                     bus.fetch_count, h_cnt);
        end
    endtask

    task automatic test_illegal();
        logic [31:0] w [4];
        logic        v [4];
        logic        xi [4];
        logic        xv [4];
        w[0] = 32'hFFFFFFFF; v[0] = 1; xi[0] = 1; xv[0] = 1;
        w[1] = 32'h00000000; v[1] = 1; xi[1] = 0; xv[1] = 1;
        w[2] = 32'hFFFFFFFF; v[2] = 0; xi[2] = 0; xv[2] = 0;
        w[3] = 32'h12345678; v[3] = 1; xi[3] = 1; xv[3] = 1;
        for (int i = 0; i < 4; i++) begin
            drive(w[i], v[i], 1'b0, 1'b0);
            step();
            checks++;
            if (bus.illegal !== xi[i] || bus.imm_valid !== xv[i] ||
                bus.imm_kind !== 3'd0 || bus.imm !== 64'd0) begin
                errors++;
                $display("FAIL illegal%0d: ill=%b v=%b kind=%0d imm=%h required ill=%b v=%b kind=0 imm=0",
                         i, bus.illegal, bus.imm_valid, bus.imm_kind,
                         bus.imm, xi[i], xv[i]);
            end
        end
    endtask

    task automatic test_random();
        for (int i = 0; i < 400; i++) begin
            drive(rnd_instr(), 1'($urandom_range(0, 3) != 0),
                  1'($urandom_range(0, 4) == 0),
                  1'($urandom_range(0, 9) == 0));
            step();
            checks++;
            if (bus.imm !== e_imm || bus.imm_kind !== e_kind ||
                bus.imm_valid !== e_valid || bus.illegal !== e_ill ||
                bus.fetch_count !== e_cnt) begin
                errors++;
                $display("FAIL random%0d: imm=%h kind=%0d v=%b ill=%b cnt=%0d required imm=%h kind=%0d v=%b ill=%b cnt=%0d",
                         i, bus.imm, bus.imm_kind, bus.imm_valid,
                         bus.illegal, bus.fetch_count, e_imm, e_kind,
                         e_valid, e_ill, e_cnt);
            end
        end
    endtask

    task automatic test_wrap_reset();
        reset = 1'b1;
        drive(32'd0, 1'b0, 1'b0, 1'b0);
        step();
        reset = 1'b0;
        for (int i = 0; i < 65535; i++) begin
            drive(rnd_instr(), 1'b1, 1'b0, 1'b0);
            step();
        end
        checks++;
        if (bus.fetch_count !== 16'hFFFF || e_cnt !== 16'hFFFF) begin
            errors++;
            $display("FAIL count_max: cnt=%h required FFFF",
                     bus.fetch_count);
        end
        drive(32'd0, 1'b1, 1'b0, 1'b0);
        step();
        checks++;
        if (bus.fetch_count !== 16'h0000) begin
            errors++;
            $display("FAIL count_wrap: cnt=%h required 0000",
                     bus.fetch_count);
        end
        drive({11'b11111000000, 9'h0FF, 12'd0}, 1'b1, 1'b0, 1'b0);
        step();
        drive(rnd_instr(), 1'b1, 1'b1, 1'b0);
        step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        checks++;
        if ({bus.imm, bus.imm_kind, bus.imm_valid, bus.illegal,
             bus.fetch_count} !== 86'd0) begin
            errors++;
            $display("FAIL reset_mid: imm=%h kind=%0d v=%b ill=%b cnt=%0d required all zero",
                     bus.imm, bus.imm_kind, bus.imm_valid, bus.illegal,
                     bus.fetch_count);
        end
        drive({10'b1101000100, 12'h123, 10'd0}, 1'b1, 1'b0, 1'b0);
        step();
        checks++;
        if (bus.imm !== 64'h123 || bus.imm_kind !== 3'd2 ||
            bus.imm_valid !== 1'b1 || bus.fetch_count !== 16'd1) begin
            errors++;
            $display("FAIL first_after_reset: imm=%h kind=%0d v=%b cnt=%0d required imm=123 kind=2 v=1 cnt=1",
                     bus.imm, bus.imm_kind, bus.imm_valid,
                     bus.fetch_count);
        end
    endtask

    initial begin
        drive(32'd0, 1'b0, 1'b0, 1'b0);
        e_imm = 0; e_kind = 0; e_valid = 0; e_ill = 0; e_cnt = 0;
        test_reset();
        test_directed();
        test_stall_flush();
        test_illegal();
        test_random();
        test_wrap_reset();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/imm_decode_stage.md
IMM_DECODE_STAGE -- requirements
Module: imm_decode_stage

Interface
REQ-001 SHALL have parameter BR_SHIFT, default 2: left-shift applied to branch offsets (bytes per instruction word, log2).
REQ-002 SHALL have port clk, input, 1: the single clock; all state updates on its rising edge.
REQ-003 SHALL have port reset, input, 1: synchronous, active-high reset.
REQ-004 SHALL have port instr, input, 32: IF/ID instruction word.
REQ-005 SHALL have port instr_valid, input, 1: instr holds a real instruction this cycle.
REQ-006 SHALL have port stall, input, 1: hazard unit hold request.
REQ-007 SHALL have port flush, input, 1: branch-taken squash request.
REQ-008 SHALL have port imm, output, 64: registered extended immediate for ID/EX.
REQ-009 SHALL have port imm_kind, output, 3: registered kind (0 NONE, 1 D9, 2 I12, 3 CB19, 4 B26).
REQ-010 SHALL have port imm_valid, output, 1: registered valid for imm and imm_kind.
REQ-011 SHALL have port illegal, output, 1: registered flag, valid instruction with an unrecognised opcode.
REQ-012 SHALL have port fetch_count, output, 16: registered count of instructions accepted into the stage.

Function
REQ-013 SHALL decode kind from instr: [31:21] = 11111000010 (LDUR) or 11111000000 (STUR) -> D9; [31:22] = 1001000100 (ADDI) or 1101000100 (SUBI) -> I12; [31:24] = 10110100 (CBZ) or 01010100 (B.cond) -> CB19; [31:26] = 000101 (B) -> B26; else NONE.
REQ-014 SHALL check decode in the order D9, I12, CB19, B26; first match wins.
REQ-015 SHALL form D9 as instr[20:12] sign-extended to 64 bits.
REQ-016 SHALL form I12 as instr[21:10] zero-extended to 64 bits.
REQ-017 SHALL form CB19 as instr[23:5] sign-extended to 64 bits, then shifted left by BR_SHIFT; bits shifted out are discarded.
REQ-018 SHALL form B26 as instr[25:0] sign-extended to 64 bits, then shifted left by BR_SHIFT; bits shifted out are discarded.
REQ-019 SHALL form NONE as imm = 0.
REQ-020 SHALL have one-cycle latency: the decode of instr at edge N appears on the outputs after edge N.
REQ-021 SHALL, on flush = 1 (regardless of stall), load imm_valid = 0, imm = 0, imm_kind = 0, illegal = 0 at the next edge.
REQ-022 SHALL, on flush = 1 with stall = 1, apply the flush; flush wins.
REQ-023 SHALL, on stall = 1 with flush = 0, hold all outputs unchanged, including fetch_count.
REQ-024 SHALL, otherwise, load decoded imm and imm_kind, imm_valid = instr_valid, and illegal = instr_valid AND (kind = NONE) AND (instr != 0).
REQ-025 SHALL treat instr = 0 with instr_valid = 1 as a NOP: imm_valid = 1, kind NONE, illegal = 0.
REQ-026 SHALL, when instr_valid = 0, load imm and imm_kind as decoded but force illegal = 0.
REQ-027 SHALL increment fetch_count by 1 on each edge with instr_valid = 1, stall = 0, flush = 0.
REQ-028 SHALL let fetch_count wrap from 16'hFFFF to 0 without a flag.
REQ-029 SHALL hold illegal for exactly as long as the illegal entry sits in the stage; it is cleared by the next load or by flush.

Reset
REQ-030 SHALL, on reset = 1 at an edge, set imm = 0, imm_kind = 0, imm_valid = 0, illegal = 0, fetch_count = 0, overriding stall and flush.
REQ-031 SHALL, on reset asserted mid-stall, discard the held entry at the next edge.
REQ-032 SHALL, with reset deasserted, accept the first instruction at the following edge.

Verification
REQ-033 SHALL cover: LDUR with DAddr 9'h1F8, valid -> next cycle imm = 64'hFFFFFFFFFFFFFFF8, kind 1, valid 1, fetch_count 1.
REQ-034 SHALL cover: ADDI with imm12 12'hFFF -> imm = 64'h0000000000000FFF, kind 2 (zero-extended, not sign-extended).
REQ-035 SHALL cover: B with imm26 = 26'h3FFFFFF -> imm = 64'hFFFFFFFFFFFFFFFC, kind 4; B.cond with imm19 = 2 -> imm = 64'h8, kind 3.
REQ-036 SHALL cover: stall high for 3 cycles while instr changes -> outputs and fetch_count frozen; then flush with stall high -> imm_valid 0, imm 0.
REQ-037 SHALL cover: valid 32'hFFFFFFFF (no opcode match) -> illegal 1, kind 0; valid 32'h0 -> illegal 0, imm_valid 1.
REQ-038 SHALL cover: fetch_count preset to 16'hFFFF by 65535 accepts, one more accept -> 0; reset mid-stream -> all outputs 0 next cycle.
